// File: rtl/regfile_wb_arbiter.sv
// Two-source register-file writeback arbiter, one-entry buffer per source, registered write port.
// Optional round-robin tie-breaking for different-address contention: define WB_ARB_RR_EN.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        busy
);

    logic        full0, full1;
    logic        young0, young1;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        pick1, grant0, grant1;
    logic        load0, load1, stay0, stay1;
`ifdef WB_ARB_RR_EN
    logic        rr_ptr;
`endif

    // Same-address contention must preserve program order; a buffer without the
    // young bit is the older one, and simultaneous loads favour source 1.
    always_comb begin
        pick1 = 1'b0;
        if (full0 && full1) begin
            if (addr0 == addr1) begin
                pick1 = !young1;
            end else begin
`ifdef WB_ARB_RR_EN
                pick1 = rr_ptr;
`else
                pick1 = 1'b1;
`endif
            end
        end else begin
            pick1 = full1;
        end
    end

    assign grant0 = full0 && !pick1;
    assign grant1 = full1 && pick1;

    assign req0_ready = (!full0 || grant0) && !flush && !rst;
    assign req1_ready = (!full1 || grant1) && !flush && !rst;

    assign load0 = req0_valid && req0_ready && (req0_addr != 5'd0);
    assign load1 = req1_valid && req1_ready && (req1_addr != 5'd0);
    assign stay0 = full0 && !grant0;
    assign stay1 = full1 && !grant1;

    assign busy = full0 || full1 || we;

    always_ff @(posedge clk) begin
        if (rst) begin
            full0  <= 1'b0;
            full1  <= 1'b0;
            young0 <= 1'b0;
            young1 <= 1'b0;
            addr0  <= 5'd0;
            addr1  <= 5'd0;
            data0  <= 32'd0;
            data1  <= 32'd0;
            we     <= 1'b0;
            waddr  <= 5'd0;
            wdata  <= 32'd0;
`ifdef WB_ARB_RR_EN
            rr_ptr <= 1'b0;
`endif
        end else if (flush) begin
            full0  <= 1'b0;
            full1  <= 1'b0;
            young0 <= 1'b0;
            young1 <= 1'b0;
            we     <= 1'b0;
        end else begin
            we <= grant0 || grant1;
            if (grant0 || grant1) begin
                waddr <= pick1 ? addr1 : addr0;
                wdata <= pick1 ? data1 : data0;
`ifdef WB_ARB_RR_EN
                rr_ptr <= !pick1;
`endif
            end
            full0 <= load0 || stay0;
            full1 <= load1 || stay1;
            if (load0) begin
                addr0 <= req0_addr;
                data0 <= req0_data;
            end
            if (load1) begin
                addr1 <= req1_addr;
                data1 <= req1_data;
            end
            // A fresh entry is younger only if the other buffer keeps its entry
            // across this edge; any change to the other buffer ends the ordering.
            young0 <= load0 ? stay1 : (young0 && stay0 && stay1);
            young1 <= load1 ? stay0 : (young1 && stay1 && stay0);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed literal checks plus randomized traffic against a
// timestamp-ordered pending-entry model, compared every cycle.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_addr, req1_addr, waddr;
    logic [31:0] req0_data, req1_data, wdata;
    logic        we, busy;

    int checks = 0;
    int errors = 0;

    // Pending entries carry the edge number at which they were loaded.
    logic        mv[2];
    logic [4:0]  ma[2];
    logic [31:0] md[2];
    int          ms[2];
    int          seq;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_last;
    logic        r0_seen, r1_seen;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (mv[0] && mv[1]) begin
            if (ma[0] == ma[1]) return (ms[0] < ms[1]) ? 0 : 1;
`ifdef WB_ARB_RR_EN
            return m_last ? 0 : 1;
`else
            return 1;
`endif
        end
        if (mv[0]) return 0;
        if (mv[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        mv[0] = 1'b0; mv[1] = 1'b0;
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        m_last = 1'b1;
    endtask

    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic fl, input logic rs);
        int   g;
        logic er0, er1;
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        flush = fl; rst = rs;
        #1;
        g   = model_grant();
        er0 = (!mv[0] || g == 0) && !fl && !rs;
        er1 = (!mv[1] || g == 1) && !fl && !rs;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
        chk("we", {31'd0, we}, {31'd0, m_we});
        chk("waddr", {27'd0, waddr}, {27'd0, m_waddr});
        chk("wdata", wdata, m_wdata);
        chk("busy", {31'd0, busy}, {31'd0, mv[0] || mv[1] || m_we});
        r0_seen = req0_ready;
        r1_seen = req1_ready;
        if (rs) begin
            model_reset();
        end else if (fl) begin
            mv[0] = 1'b0; mv[1] = 1'b0; m_we = 1'b0;
        end else begin
            if (g >= 0) begin
                m_we = 1'b1; m_waddr = ma[g]; m_wdata = md[g];
                mv[g] = 1'b0; m_last = g[0];
            end else begin
                m_we = 1'b0;
            end
            if (v0 && er0 && a0 != 5'd0) begin mv[0] = 1'b1; ma[0] = a0; md[0] = d0; ms[0] = seq; end
            if (v1 && er1 && a1 != 5'd0) begin mv[1] = 1'b1; ma[1] = a1; md[1] = d1; ms[1] = seq; end
        end
        seq++;
        @(posedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic rst_cycle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic lit(input string nm, input logic e_we, input logic [4:0] e_addr,
                       input logic [31:0] e_data, input logic e_busy, input logic chk_data);
        #1;
        chk({nm, ".we"}, {31'd0, we}, {31'd0, e_we});
        chk({nm, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        if (chk_data) begin
            chk({nm, ".waddr"}, {27'd0, waddr}, {27'd0, e_addr});
            chk({nm, ".wdata"}, wdata, e_data);
        end
    endtask

    initial begin
        seq = 0;
        ms[0] = 0; ms[1] = 0;
        ma[0] = 5'd0; ma[1] = 5'd0; md[0] = 32'd0; md[1] = 32'd0;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
        flush = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        lit("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Single write: two-edge latency, then idle.
        cycle(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        lit("single.load", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle();
        lit("single.write", 1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 1'b1);
        idle();
        lit("single.done", 1'b0, 5'd5, 32'hA5A5A5A5, 1'b0, 1'b1);

        // Writes to x0 are swallowed.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("x0.ready", {31'd0, r1_seen}, 32'd1);
        lit("x0.a", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        idle();
        lit("x0.b", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Different-address contention right after reset.
        rst_cycle();
        cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
        idle();
`ifdef WB_ARB_RR_EN
        lit("cont.first", 1'b1, 5'd3, 32'h33, 1'b1, 1'b1);
        idle();
        lit("cont.second", 1'b1, 5'd4, 32'h44, 1'b1, 1'b1);
`else
        lit("cont.first", 1'b1, 5'd4, 32'h44, 1'b1, 1'b1);
        idle();
        lit("cont.second", 1'b1, 5'd3, 32'h33, 1'b1, 1'b1);
`endif
        idle();
        lit("cont.done", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Same-address hazard: older data lands first.
        cycle(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2, 1'b0, 1'b0);
        lit("haz.first", 1'b1, 5'd7, 32'd1, 1'b1, 1'b1);
        idle();
        lit("haz.second", 1'b1, 5'd7, 32'd2, 1'b1, 1'b1);
        idle();

        // Back-to-back stream from source 0.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            chk("b2b.ready", {31'd0, r0_seen}, 32'd1);
            if (i >= 2) lit("b2b.write", 1'b1, 5'(i - 1), 32'((i - 1) * 16), 1'b1, 1'b1);
        end
        idle();
        lit("b2b.last", 1'b1, 5'd4, 32'h40, 1'b1, 1'b1);
        idle();
        lit("b2b.done", 1'b0, 5'd4, 32'h40, 1'b0, 1'b1);

        // Flush with both buffers full.
        cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0);
        lit("flush.a", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        idle();
        lit("flush.b", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        idle();
        lit("flush.c", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Reset with both buffers full and a nonzero write port.
        cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        idle();
        lit("rst.pre", 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
        cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
        cycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd2, 32'h22, 1'b1, 1'b1);
        lit("rst.a", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        idle();
        lit("rst.b", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        // Random traffic on a small address set to provoke same-address ordering.
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
